// File: rtl/config_word_packer.sv
// config_word_packer: packs received bytes big-endian into 32-bit config words, with idle-timeout sessions; optional checksum via CFG_PACKER_CHECKSUM_EN
module config_word_packer #(
  parameter int IdleTimeout  = 50000,
  parameter int TimeoutWidth = 16
) (
  input  logic        CLK,
  input  logic        resetn,
  input  logic [7:0]  RxData,
  input  logic        RxValid,
  output logic [31:0] WriteData,
  output logic        WriteStrobe,
  output logic        ComActive,
  output logic [15:0] WordCount,
  output logic [7:0]  Checksum
);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;
  logic [0:0]              state_q, state_d;
  logic [1:0]              idx_q, idx_d;
  logic [TimeoutWidth-1:0] idle_q, idle_d;
  logic [23:0]             part_q, part_d;
  logic [31:0]             data_q, data_d;
  logic                    strobe_q, strobe_d;
  logic [15:0]             wc_q, wc_d;
  logic [1:0]              pos;
  logic                    timeout;
  // a byte arriving in IDLE always lands in slot 0, whatever index the last session left
  assign pos     = (state_q == IDLE) ? 2'd0 : idx_q;
  assign timeout = idle_q == TimeoutWidth'(IdleTimeout);
  // next state: an accepted byte always wins over the idle timeout
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    idle_d   = idle_q;
    part_d   = part_q;
    data_d   = data_q;
    strobe_d = 1'b0;
    wc_d     = wc_q;
    if (RxValid) begin
      state_d  = ACTIVE;
      idle_d   = '0;
      idx_d    = pos + 2'd1;
      part_d   = {pos == 2'd0 ? RxData : part_q[23:16],
                  pos == 2'd1 ? RxData : part_q[15:8],
                  pos == 2'd2 ? RxData : part_q[7:0]};
      data_d   = (pos == 2'd3) ? {part_q, RxData} : data_q;
      strobe_d = pos == 2'd3;
      wc_d     = (state_q == IDLE) ? 16'd0 :
                 (pos == 2'd3 && wc_q != 16'hFFFF) ? wc_q + 16'd1 : wc_q;
    end else if (state_q == ACTIVE) begin
      state_d = timeout ? IDLE : ACTIVE;
      idx_d   = timeout ? 2'd0 : idx_q;
      idle_d  = timeout ? '0 : idle_q + 1'b1;
    end
  end
  // state registers, cleared immediately on reset
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      idle_q   <= '0;
      part_q   <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
      wc_q     <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      idle_q   <= idle_d;
      part_q   <= part_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      wc_q     <= wc_d;
    end
  end
`ifdef CFG_PACKER_CHECKSUM_EN
  logic [7:0] cks_q, cks_d;
  assign cks_d = !RxValid ? cks_q : (state_q == IDLE) ? RxData : cks_q + RxData;
  // running byte sum, restarted by the first byte of each session
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) cks_q <= '0;
    else         cks_q <= cks_d;
  end
  assign Checksum = cks_q;
`else
  assign Checksum = 8'd0;
`endif
  assign WriteData   = data_q;
  assign WriteStrobe = strobe_q;
  assign ComActive   = state_q == ACTIVE;
  assign WordCount   = wc_q;
endmodule

// File: tb/tb_config_word_packer.sv
// tb_config_word_packer: table-driven and scoreboard bench for config_word_packer
module tb_config_word_packer;
  localparam int TO = 8;
`ifdef CFG_PACKER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  logic        CLK = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  RxData = 8'd0;
  logic        RxValid = 1'b0;
  logic [31:0] WriteData;
  logic        WriteStrobe;
  logic        ComActive;
  logic [15:0] WordCount;
  logic [7:0]  Checksum;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  typedef struct {
    logic [31:0] bytes;
    logic [31:0] exp_word;
    logic [15:0] exp_wc;
    int          gap;
  } vec_t;
  typedef struct {
    logic [31:0] w;
    logic [15:0] wc;
    int          gap;
  } exp_t;
  vec_t tbl[4];
  exp_t sb[$];
  config_word_packer #(.IdleTimeout(TO), .TimeoutWidth(16)) dut (
    .CLK(CLK), .resetn(resetn), .RxData(RxData), .RxValid(RxValid),
    .WriteData(WriteData), .WriteStrobe(WriteStrobe), .ComActive(ComActive),
    .WordCount(WordCount), .Checksum(Checksum)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  task automatic send(input logic [7:0] b);
    @(negedge CLK);
    RxData = b;
    RxValid = 1'b1;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      RxValid = 1'b0;
    end
  endtask
  task automatic send_word(input logic [31:0] b, input logic [31:0] w, input logic [15:0] wc, input int gap);
    exp_t e;
    send(b[31:24]);
    send(b[23:16]);
    send(b[15:8]);
    e.w = w;
    e.wc = wc;
    e.gap = gap;
    sb.push_back(e);
    send(b[7:0]);
  endtask
  initial begin
    int last_cyc;
    exp_t e;
    last_cyc = 0;
    tbl[0] = '{32'hFAB0FAB1, 32'hFAB0FAB1, 16'd1, 0};
    tbl[1] = '{32'h00010203, 32'h00010203, 16'd1, 0};
    tbl[2] = '{32'h04050607, 32'h04050607, 16'd2, 4};
    tbl[3] = '{32'h08090A0B, 32'h08090A0B, 16'd3, 4};
    fork
      forever begin
        @(negedge CLK);
        if (resetn && WriteStrobe) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: got data %h expected no strobe (cycle %0d)", WriteData, cyc);
          end else begin
            e = sb.pop_front();
            chk("strobe_data", WriteData, e.w);
            chk("strobe_wc", {16'd0, WordCount}, {16'd0, e.wc});
            chk("strobe_active", {31'd0, ComActive}, 32'd1);
            if (e.gap != 0) chk("strobe_gap", cyc - last_cyc, e.gap);
          end
          last_cyc = cyc;
        end
      end
    join_none
    repeat (2) @(negedge CLK);
    chk("rst_active", {31'd0, ComActive}, 32'd0);
    chk("rst_strobe", {31'd0, WriteStrobe}, 32'd0);
    chk("rst_data", WriteData, 32'd0);
    chk("rst_wc", {16'd0, WordCount}, 32'd0);
    chk("rst_cks", {24'd0, Checksum}, 32'd0);
    resetn = 1'b1;
    send_word(tbl[0].bytes, tbl[0].exp_word, tbl[0].exp_wc, tbl[0].gap);
    idle(1);
    chk("w0_active", {31'd0, ComActive}, 32'd1);
    chk("w0_wc", {16'd0, WordCount}, 32'd1);
    idle(12);
    chk("w0_timeout", {31'd0, ComActive}, 32'd0);
    chk("w0_wc_hold", {16'd0, WordCount}, 32'd1);
    for (int i = 1; i < 4; i++) send_word(tbl[i].bytes, tbl[i].exp_word, tbl[i].exp_wc, tbl[i].gap);
    idle(1);
    chk("b2b_wc", {16'd0, WordCount}, 32'd3);
    chk("b2b_cks", {24'd0, Checksum}, CK ? 32'h42 : 32'h0);
    idle(12);
    send(8'hA1);
    send(8'hA2);
    idle(9);
    chk("to_before", {31'd0, ComActive}, 32'd1);
    idle(1);
    chk("to_after", {31'd0, ComActive}, 32'd0);
    chk("to_data_hold", WriteData, 32'h08090A0B);
    send(8'hC1);
    chk("new_low", {31'd0, ComActive}, 32'd0);
    send(8'hC2);
    chk("new_rise", {31'd0, ComActive}, 32'd1);
    send(8'hC3);
    e.w = 32'hC1C2C3C4;
    e.wc = 16'd1;
    e.gap = 0;
    sb.push_back(e);
    send(8'hC4);
    send(8'hD1);
    idle(8);
    send(8'hD2);
    send(8'hD3);
    chk("race_active", {31'd0, ComActive}, 32'd1);
    e.w = 32'hD1D2D3D4;
    e.wc = 16'd2;
    sb.push_back(e);
    send(8'hD4);
    idle(1);
    chk("race_wc", {16'd0, WordCount}, 32'd2);
    idle(12);
    send_word(32'hFF020304, 32'hFF020304, 16'd1, 0);
    idle(1);
    chk("cks_value", {24'd0, Checksum}, CK ? 32'h08 : 32'h0);
    send(8'h55);
    send(8'h66);
    send(8'h77);
    @(negedge CLK);
    RxValid = 1'b0;
    resetn = 1'b0;
    #1;
    chk("mid_rst_active", {31'd0, ComActive}, 32'd0);
    chk("mid_rst_data", WriteData, 32'd0);
    chk("mid_rst_wc", {16'd0, WordCount}, 32'd0);
    chk("mid_rst_cks", {24'd0, Checksum}, 32'd0);
    @(negedge CLK);
    resetn = 1'b1;
    send_word(32'h11223344, 32'h11223344, 16'd1, 0);
    idle(2);
    chk("post_rst_data", WriteData, 32'h11223344);
    chk("post_rst_wc", {16'd0, WordCount}, 32'd1);
    chk("sb_drain", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
